// File: rtl/instr_encoder.sv
// Two-stage RISC-V instruction encoder: decoded fields + signed immediate in, packed word + byte address out.
// Optional range checking of the immediate is enabled by defining INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int                 ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    localparam logic [2:0]  FMT_I = 3'b000;
    localparam logic [2:0]  FMT_S = 3'b001;
    localparam logic [2:0]  FMT_B = 3'b010;
    localparam logic [2:0]  FMT_J = 3'b011;
    localparam logic [2:0]  FMT_U = 3'b100;
    localparam logic [2:0]  FMT_R = 3'b101;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic              r_s1_valid;
    logic [2:0]        r_fmt;
    logic [6:0]        r_op;
    logic [4:0]        r_rd;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [2:0]        r_f3;
    logic [6:0]        r_f7;
    logic [31:0]       r_imm;

    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic              r_out_err;
    logic [ADDR_W-1:0] r_addr;

    logic              w_s2_load;
    logic              w_s1_load;
    logic [31:0]       w_instr;
    logic              w_err;

    assign w_s2_load = !r_out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_err   = r_out_err;
    assign out_addr  = r_addr;

    always_comb begin
        w_instr = NOP;
        case (r_fmt)
            FMT_I: w_instr = {r_imm[11:0], r_rs1, r_f3, r_rd, r_op};
            FMT_S: w_instr = {r_imm[11:5], r_rs2, r_rs1, r_f3, r_imm[4:0], r_op};
            FMT_B: w_instr = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_f3,
                              r_imm[4:1], r_imm[11], r_op};
            FMT_J: w_instr = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_op};
            FMT_U: w_instr = {r_imm[31:12], r_rd, r_op};
            FMT_R: w_instr = {r_f7, r_rs2, r_rs1, r_f3, r_rd, r_op};
            default: w_instr = NOP;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic w_fits12;
    logic w_fits13;
    logic w_fits21;

    // Sign-extension checks: the upper bits must all equal the encoded sign bit.
    assign w_fits12 = (&r_imm[31:11]) || !(|r_imm[31:11]);
    assign w_fits13 = (&r_imm[31:12]) || !(|r_imm[31:12]);
    assign w_fits21 = (&r_imm[31:20]) || !(|r_imm[31:20]);

    always_comb begin
        w_err = 1'b0;
        case (r_fmt)
            FMT_I, FMT_S: w_err = !w_fits12;
            FMT_B:        w_err = !w_fits13 || r_imm[0];
            FMT_J:        w_err = !w_fits21 || r_imm[0];
            FMT_U:        w_err = |r_imm[11:0];
            FMT_R:        w_err = 1'b0;
            default:      w_err = 1'b1;
        endcase
    end
`else
    assign w_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_fmt      <= '0;
            r_op       <= '0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_f3       <= '0;
            r_f7       <= '0;
            r_imm      <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_fmt <= in_fmt;
                r_op  <= in_opcode;
                r_rd  <= in_rd;
                r_rs1 <= in_rs1;
                r_rs2 <= in_rs2;
                r_f3  <= in_funct3;
                r_f7  <= in_funct7;
                r_imm <= in_imm;
            end
        end
    end

    // The address tracks the word currently presented, so it advances on the output handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_err   <= 1'b0;
            r_addr      <= BASE_ADDR;
        end else begin
            if (w_s2_load) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_instr <= w_instr;
                    r_out_err   <= w_err;
                end
            end
            if (r_out_valid && out_ready) begin
                r_addr <= r_addr + ADDR_W'(4);
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a scoreboard queue; a second instance checks address wrap.
// Expected error flags follow INSTR_ENCODER_RANGE_CHECK_EN.
module tb_instr_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        out_err;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_instr2;
    logic [3:0]  out_addr2;
    logic        out_err2;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        q[$];
    exp_t        exp_cur;
    logic [7:0]  exp_addr;
    logic [3:0]  exp_addr2;
    int          n_checks;
    int          n_pass;
    int          stalls;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'h00)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) u_wrap (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_instr(out_instr2), .out_addr(out_addr2), .out_err(out_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Scoreboard push on accept and pop on output handshake, both sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            exp_addr  = 8'h00;
            exp_addr2 = 4'hC;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("instr", out_instr, e.instr);
                    chk("err", {31'b0, out_err}, {31'b0, e.err});
                    chk("addr", {24'b0, out_addr}, {24'b0, exp_addr});
                    chk("wrap_valid", {31'b0, out_valid2}, 32'd1);
                    chk("wrap_instr", out_instr2, e.instr);
                    chk("wrap_addr", {28'b0, out_addr2}, {28'b0, exp_addr2});
                    exp_addr  = exp_addr + 8'd4;
                    exp_addr2 = exp_addr2 + 4'd4;
                end
            end
            if (in_valid && in_ready) q.push_back(exp_cur);
        end
    end

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm,
                         input logic [31:0] e_instr, input logic e_err);
        in_fmt    = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        exp_cur.instr = e_instr;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        exp_cur.err = e_err;
`else
        exp_cur.err = 1'b0;
        if (e_err) exp_cur.err = 1'b0;
`endif
        in_valid = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] e_instr, input logic e_err, output int n_stall);
        drive(fmt, op, rd, rs1, rs2, f3, f7, imm, e_instr, e_err);
        n_stall = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n_stall++;
            if (n_stall >= 50) begin
                chk("send_accept", {31'b0, in_ready}, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        exp_addr  = 8'h00;
        exp_addr2 = 4'hC;
        exp_cur   = '0;
        out_ready = 1'b1;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        do_reset();

        @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_err", {31'b0, out_err}, 32'd0);
        chk("rst_addr", {24'b0, out_addr}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_wrap_addr", {28'b0, out_addr2}, 32'hC);
        @(posedge clk); #1;

        // addi x1, x0, 5: valid two edges after the accepting cycle's inputs are presented
        send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0, stalls);
        @(negedge clk);
        chk("lat_not_yet", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_instr", out_instr, 32'h0050_0093);
        @(posedge clk); #1;
        repeat (2) @(posedge clk); #1;

        // beq / jal / lui back to back
        do_reset();
        send(3'b010, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, stalls);
        chk("b2b_stall0", stalls, 32'd0);
        send(3'b011, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_00EF, 1'b0, stalls);
        chk("b2b_stall1", stalls, 32'd0);
        send(3'b100, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_5137, 1'b0, stalls);
        chk("b2b_stall2", stalls, 32'd0);
        @(negedge clk);
        chk("b2b_v1", {31'b0, out_valid}, 32'd1);
        chk("b2b_a1", {24'b0, out_addr}, 32'h04);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_v2", {31'b0, out_valid}, 32'd1);
        chk("b2b_a2", {24'b0, out_addr}, 32'h08);
        @(posedge clk); #1;

        // range violations and illegal format; R ignores the immediate
        send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, 1'b1, stalls);
        send(3'b100, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_5137, 1'b1, stalls);
        send(3'b010, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0163, 1'b1, stalls);
        send(3'b110, 7'h33, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'd0, 32'h0000_0013, 1'b1, stalls);
        send(3'b101, 7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0073_02B3, 1'b0, stalls);
        send(3'b001, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_F800, 32'h8020_A023, 1'b0, stalls);
        repeat (4) @(posedge clk); #1;

        // backpressure: two accepts, third stalls, outputs frozen
        do_reset();
        out_ready = 1'b0;
        send(3'b000, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0193, 1'b0, stalls);
        send(3'b101, 7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'd0, 32'd0, 32'h0073_02B3, 1'b0, stalls);
        chk("bp_stall", stalls, 32'd0);
        drive(3'b001, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_hold_instr", out_instr, 32'h0010_0193);
            chk("bp_hold_addr", {24'b0, out_addr}, 32'h00);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk); #1;

        // reset with both stages full
        out_ready = 1'b0;
        send(3'b000, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0070_0213, 1'b0, stalls);
        send(3'b000, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 32'h0090_0293, 1'b0, stalls);
        @(negedge clk);
        chk("mid_full", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_addr", {24'b0, out_addr}, 32'h00);
        chk("mid_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_wrap_ready", {31'b0, in_ready2}, 32'd1);
        chk("mid_wrap_err", {31'b0, out_err2}, 32'd0);
        @(posedge clk); #1;
        send(3'b011, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_00EF, 1'b0, stalls);

        for (int i = 0; i < 50; i++) begin
            if (q.size() == 0) break;
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk); #1;
        chk("drain", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
